// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/done handshake.
// Signed or unsigned operands (tc), product held until the next completion.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 tc,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [WIDTH+1:0]     r_a;
  logic [WIDTH:0]       r_m;
  logic [WIDTH:0]       r_q;
  logic                 r_q1;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_load;
  logic                 w_last;
  logic [WIDTH:0]       w_m_ext;
  logic [WIDTH:0]       w_q_ext;
  logic [WIDTH+1:0]     w_m_wide;
  logic [WIDTH+1:0]     w_sum;
  logic [WIDTH+1:0]     w_a_nxt;
  logic [WIDTH:0]       w_q_nxt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One extra bit makes unsigned operands non-negative under Booth recoding.
  assign w_m_ext  = tc ? {multiplicand[WIDTH-1], multiplicand} : {1'b0, multiplicand};
  assign w_q_ext  = tc ? {multiplier[WIDTH-1], multiplier}     : {1'b0, multiplier};
  assign w_m_wide = {r_m[WIDTH], r_m};

  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_q1})
      2'b01:   w_sum = r_a + w_m_wide;
      2'b10:   w_sum = r_a - w_m_wide;
      default: w_sum = r_a;
    endcase
  end

  assign w_a_nxt = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
  assign w_q_nxt = {w_sum[0], r_q[WIDTH:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_load) begin
      r_a   <= '0;
      r_m   <= w_m_ext;
      r_q   <= w_q_ext;
      r_q1  <= 1'b0;
      r_cnt <= CNT_INIT;
    end else if (r_state == S_CALC) begin
      r_a   <= w_a_nxt;
      r_q   <= w_q_nxt;
      r_q1  <= r_q[0];
      r_cnt <= r_cnt - CNT_LAST;
      if (w_last) r_product <= {w_a_nxt[WIDTH-2:0], w_q_nxt};
    end
  end

  assign product = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: four widths, directed table,
// back-to-back, reset abort and randomized regression against an arithmetic model.
module tb_booth_mult_seq;

  logic        clk;
  logic        rst;
  logic [3:0]  start_v;
  logic        tcv;
  logic [31:0] mc;
  logic [31:0] mp;

  logic        b4, b5, b8, b16;
  logic        d4, d5, d8, d16;
  logic [7:0]  p4;
  logic [9:0]  p5;
  logic [15:0] p8;
  logic [31:0] p16;

  int tests;
  int fails;

  booth_mult_seq #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .tc(tcv),
    .multiplicand(mc[3:0]), .multiplier(mp[3:0]),
    .busy(b4), .done(d4), .product(p4));

  booth_mult_seq #(.WIDTH(5)) u_w5 (
    .clk(clk), .rst(rst), .start(start_v[1]), .tc(tcv),
    .multiplicand(mc[4:0]), .multiplier(mp[4:0]),
    .busy(b5), .done(d5), .product(p5));

  booth_mult_seq #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .tc(tcv),
    .multiplicand(mc[7:0]), .multiplier(mp[7:0]),
    .busy(b8), .done(d8), .product(p8));

  booth_mult_seq #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .start(start_v[3]), .tc(tcv),
    .multiplicand(mc[15:0]), .multiplier(mp[15:0]),
    .busy(b16), .done(d16), .product(p16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int width_of(input int idx);
    case (idx)
      0: return 4;
      1: return 5;
      2: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic get_busy(input int idx);
    case (idx)
      0: return b4;
      1: return b5;
      2: return b8;
      default: return b16;
    endcase
  endfunction

  function automatic logic get_done(input int idx);
    case (idx)
      0: return d4;
      1: return d5;
      2: return d8;
      default: return d16;
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int idx);
    case (idx)
      0: return {24'd0, p4};
      1: return {22'd0, p5};
      2: return {16'd0, p8};
      default: return p16;
    endcase
  endfunction

  // Exact integer product, reduced to 2*w bits.
  function automatic logic [31:0] ref_prod(input int w, input bit t,
                                           input logic [31:0] a, input logic [31:0] b);
    longint va, vb, full, pmask;
    longint one = 64'sd1;
    va = longint'(a) & ((one << w) - 1);
    vb = longint'(b) & ((one << w) - 1);
    if (t && va >= (one << (w - 1))) va = va - (one << w);
    if (t && vb >= (one << (w - 1))) vb = vb - (one << w);
    full  = va * vb;
    pmask = (one << (2 * w)) - 1;
    return 32'(full & pmask);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation on DUT idx and check product, latency and single done pulse.
  task automatic run_op(input int idx, input bit t, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv, input string name);
    int w, busy_cnt, overlap;
    bit got;
    logic [31:0] prod;
    w = width_of(idx);
    @(negedge clk);
    mc = a; mp = b; tcv = t;
    start_v = '0;
    start_v[idx] = 1'b1;
    @(posedge clk);
    #1 start_v = '0;
    busy_cnt = 0; overlap = 0; got = 1'b0; prod = '0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (get_busy(idx) && get_done(idx)) overlap++;
      if (get_done(idx)) begin
        got  = 1'b1;
        prod = get_prod(idx);
      end else if (get_busy(idx)) begin
        busy_cnt++;
      end
    end
    check({name, " done_seen"}, 32'(got), 32'd1);
    check({name, " product"}, prod, expv);
    check({name, " busy_cycles"}, 32'(busy_cnt), 32'(w + 1));
    check({name, " busy_done_overlap"}, 32'(overlap), 32'd0);
    @(negedge clk);
    check({name, " done_one_cycle"}, 32'(get_done(idx)), 32'd0);
  endtask

  typedef struct {
    int          idx;
    bit          t;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[9];

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; start_v = '0; tcv = 1'b0; mc = '0; mp = '0;

    vecs[0] = '{2, 1'b1, 32'h05,   32'hFD,   32'hFFF1,     "w8_s_5x-3"};
    vecs[1] = '{2, 1'b0, 32'hFF,   32'hFF,   32'hFE01,     "w8_u_255x255"};
    vecs[2] = '{2, 1'b1, 32'hFF,   32'hFF,   32'h0001,     "w8_s_-1x-1"};
    vecs[3] = '{2, 1'b1, 32'h80,   32'h80,   32'h4000,     "w8_s_min_x_min"};
    vecs[4] = '{2, 1'b1, 32'h80,   32'h7F,   32'hC080,     "w8_s_min_x_max"};
    vecs[5] = '{1, 1'b1, 32'h10,   32'h10,   32'h0100,     "w5_s_-16x-16"};
    vecs[6] = '{1, 1'b0, 32'h1F,   32'h1F,   32'h03C1,     "w5_u_31x31"};
    vecs[7] = '{0, 1'b1, 32'h8,    32'h7,    32'h00C8,     "w4_s_-8x7"};
    vecs[8] = '{3, 1'b0, 32'hFFFF, 32'hFFFF, 32'hFFFE0001, "w16_u_max_x_max"};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("reset_busy", 32'(get_busy(i)), 32'd0);
      check("reset_done", 32'(get_done(i)), 32'd0);
      check("reset_product", get_prod(i), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].idx, vecs[i].t, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Back-to-back on WIDTH=8 with start held high throughout.
    begin
      int first_at, second_at, dcount, unstable;
      logic [31:0] p1, p2;
      first_at = 0; second_at = 0; dcount = 0; unstable = 0; p1 = '0; p2 = '0;
      @(negedge clk);
      tcv = 1'b1; mc = 32'd3; mp = 32'd4;
      start_v = 4'b0100;
      @(posedge clk);
      for (int n = 1; n <= 20; n++) begin
        @(negedge clk);
        if (n == 1) begin
          mc = 32'd7; mp = 32'hFE;
        end
        if (d8) begin
          dcount++;
          if (first_at == 0) begin
            first_at = n; p1 = {16'd0, p8};
          end else begin
            second_at = n; p2 = {16'd0, p8};
          end
        end else if (first_at != 0 && second_at == 0 && {16'd0, p8} != p1) begin
          unstable++;
        end
      end
      start_v = '0;
      check("b2b_first_done_at", 32'(first_at), 32'd10);
      check("b2b_first_product", p1, 32'h000C);
      check("b2b_second_done_at", 32'(second_at), 32'd20);
      check("b2b_second_product", p2, 32'hFFF2);
      check("b2b_done_count", 32'(dcount), 32'd2);
      check("b2b_product_stable", 32'(unstable), 32'd0);
      @(negedge clk);
      @(negedge clk);
      check("b2b_back_to_idle", {30'd0, b8, d8}, 32'd0);
    end

    // Reset three cycles into CALC aborts and clears the product.
    @(negedge clk);
    tcv = 1'b1; mc = 32'd5; mp = 32'd6;
    start_v = 4'b0100;
    @(posedge clk);
    #1 start_v = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_busy", 32'(b8), 32'd0);
    check("rst_mid_done", 32'(d8), 32'd0);
    check("rst_mid_product", {16'd0, p8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(2, 1'b1, 32'h09, 32'hF9, 32'hFFC1, "after_rst_9x-7");

    // Randomized regression across widths 4, 8, 16 and both modes.
    for (int k = 0; k < 1200; k++) begin
      int idx, w;
      bit t;
      logic [31:0] a, b;
      case ($urandom_range(2, 0))
        0: idx = 0;
        1: idx = 2;
        default: idx = 3;
      endcase
      w = width_of(idx);
      t = 1'($urandom_range(1, 0));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(7, 0) == 0) a = 32'h1 << (w - 1);
      if ($urandom_range(7, 0) == 0) b = '1;
      a = a & ((32'h1 << w) - 32'h1);
      b = b & ((32'h1 << w) - 32'h1);
      run_op(idx, t, a, b, ref_prod(w, t, a, b), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
